// File: rtl/fpmult_arbiter.sv
// fpmult_arbiter
// ---------------------------------------------------------------------------
// Shares one multi-cycle fpmult single-precision multiplier among NREQ
// requesters with round-robin arbitration. The controller sequences the
// multiplier's reset/done protocol. Each product goes back to the requester
// that issued it. A watchdog aborts any operation whose multiplier fails to
// report done within TIMEOUT RUN cycles.
//
// Handshake semantics (valid/ready): a requester raises req_valid[i] with its
// operands and must hold both stable until it sees req_ready[i]. The transfer
// happens on the rising edge that ends a cycle where req_valid[i] &
// req_ready[i] is high. req_ready is one-hot and is only ever asserted in
// IDLE. resp_valid is a one-cycle, one-hot strobe with no back-pressure.
//
// Ports:
//   clk, reset_n           clock, asynchronous active-low reset
//   req_valid[NREQ]        per-requester request pending
//   req_dataa/b[32*NREQ]   operands, requester i at [32i+31:32i]
//   req_ready[NREQ]        one-hot grant (combinational, IDLE only)
//   resp_valid[NREQ]       one-hot response strobe
//   resp_result[32]        product (0 on timeout)
//   resp_timeout           operation was aborted by the watchdog
//   busy                   controller is not IDLE
//   mult_reset             active-high clear/start to fpmult
//   mult_dataa/b[32]       operands to fpmult
//   mult_result[32]        fpmult result
//   mult_done              fpmult done
//   dbg_state_o[2]         current FSM state, for observation only
// ---------------------------------------------------------------------------
module fpmult_arbiter #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [32*NREQ-1:0]   req_dataa,
  input  logic [32*NREQ-1:0]   req_datab,
  output logic [NREQ-1:0]      req_ready,
  output logic [NREQ-1:0]      resp_valid,
  output logic [31:0]          resp_result,
  output logic                 resp_timeout,
  output logic                 busy,
  output logic                 mult_reset,
  output logic [31:0]          mult_dataa,
  output logic [31:0]          mult_datab,
  input  logic [31:0]          mult_result,
  input  logic                 mult_done,
  output logic [1:0]           dbg_state_o
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(TIMEOUT) + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_RESP = 2'd3
  } state_t;

  state_t          state_q;
  logic [IW-1:0]   ptr_q;
  logic [IW-1:0]   gnt_q;
  logic [CW-1:0]   cnt_q;
  logic [31:0]     result_q;
  logic            timeout_q;
  logic [31:0]     dataa_q;
  logic [31:0]     datab_q;

  // Round-robin search: first pending requester at or above ptr_q, wrapping.
  logic            found;
  logic [IW-1:0]   gnt_idx;
  logic [IW:0]     cand;
  logic [31:0]     sel_a;
  logic [31:0]     sel_b;

  always_comb begin
    found   = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int i = 0; i < NREQ; i++) begin
      cand = {1'b0, ptr_q} + (IW+1)'(i);
      if (cand >= (IW+1)'(NREQ)) begin
        cand = cand - (IW+1)'(NREQ);
      end
      if (!found && req_valid[cand[IW-1:0]]) begin
        found   = 1'b1;
        gnt_idx = cand[IW-1:0];
      end
    end
  end

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (gnt_idx == IW'(k)) begin
        sel_a = req_dataa[32*k +: 32];
        sel_b = req_datab[32*k +: 32];
      end
    end
  end

  // Grant is gated by reset_n so no requester sees a handshake while the
  // controller is being held in reset.
  always_comb begin
    req_ready = '0;
    if (state_q == S_IDLE && reset_n && found) begin
      req_ready[gnt_idx] = 1'b1;
    end
  end

  always_comb begin
    resp_valid = '0;
    if (state_q == S_RESP) begin
      resp_valid[gnt_q] = 1'b1;
    end
  end

  assign resp_result  = result_q;
  assign resp_timeout = timeout_q;
  assign busy         = (state_q != S_IDLE);
  // The multiplier is only released from reset while an operation runs.
  assign mult_reset   = (state_q != S_RUN);
  assign mult_dataa   = dataa_q;
  assign mult_datab   = datab_q;
  assign dbg_state_o  = state_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      ptr_q     <= '0;
      gnt_q     <= '0;
      cnt_q     <= '0;
      result_q  <= '0;
      timeout_q <= 1'b0;
      dataa_q   <= '0;
      datab_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (found) begin
            gnt_q   <= gnt_idx;
            dataa_q <= sel_a;
            datab_q <= sel_b;
            state_q <= S_LOAD;
          end
        end
        S_LOAD: begin
          cnt_q   <= '0;
          state_q <= S_RUN;
        end
        S_RUN: begin
          cnt_q <= cnt_q + 1'b1;
          // Done takes priority over the watchdog on the final RUN cycle.
          if (mult_done) begin
            result_q  <= mult_result;
            timeout_q <= 1'b0;
            state_q   <= S_RESP;
          end else if (cnt_q == CW'(TIMEOUT - 1)) begin
            result_q  <= '0;
            timeout_q <= 1'b1;
            state_q   <= S_RESP;
          end
        end
        S_RESP: begin
          if (gnt_q == IW'(NREQ - 1)) begin
            ptr_q <= '0;
          end else begin
            ptr_q <= gnt_q + 1'b1;
          end
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fpmult_arbiter.sv
// Testbench for fpmult_arbiter: a stub multiplier with programmable latency,
// a transaction-level reference model checked on every cycle, directed
// scenarios with literal expectations, and a randomized traffic phase.
module tb_fpmult_arbiter;

  localparam int NREQ    = 4;
  localparam int TIMEOUT = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT ----------------
  logic [NREQ-1:0]    req_valid = '0;
  logic [32*NREQ-1:0] req_dataa = '0;
  logic [32*NREQ-1:0] req_datab = '0;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ-1:0]    resp_valid;
  logic [31:0]        resp_result;
  logic               resp_timeout;
  logic               busy;
  logic               mult_reset;
  logic [31:0]        mult_dataa;
  logic [31:0]        mult_datab;
  logic [31:0]        mult_result;
  logic               mult_done;
  logic [1:0]         dbg_state;

  fpmult_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .req_valid    (req_valid),
    .req_dataa    (req_dataa),
    .req_datab    (req_datab),
    .req_ready    (req_ready),
    .resp_valid   (resp_valid),
    .resp_result  (resp_result),
    .resp_timeout (resp_timeout),
    .busy         (busy),
    .mult_reset   (mult_reset),
    .mult_dataa   (mult_dataa),
    .mult_datab   (mult_datab),
    .mult_result  (mult_result),
    .mult_done    (mult_done),
    .dbg_state_o  (dbg_state)
  );

  // ---------------- float helpers ----------------
  // Truncating single-precision multiply for normal operands.
  function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
    logic        s;
    int          e;
    logic [47:0] p;
    logic [22:0] f;
    s = a[31] ^ b[31];
    if (a[30:23] == 8'd0 || b[30:23] == 8'd0) return {s, 31'd0};
    e = int'(a[30:23]) + int'(b[30:23]) - 127;
    p = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
    if (p[47]) begin
      f = p[46:24];
      e = e + 1;
    end else begin
      f = p[45:23];
    end
    return {s, 8'(e), f};
  endfunction

  function automatic logic [31:0] rand_float();
    logic [31:0] r;
    logic [7:0]  e;
    r = $urandom;
    e = 8'($urandom_range(100, 154));
    return {r[31], e, r[22:0]};
  endfunction

  // ---------------- stub multiplier ----------------
  int          run_cyc = 0;
  int          cur_lat = 0;
  bit          lat_mode = 1'b1;        // 1: fixed latency, 0: random per op
  int          lat_fixed = 2;
  bit          override_en = 1'b0;
  logic [31:0] override_val = '0;
  logic        done_noise = 1'b0;
  logic [31:0] noise_word = '0;
  logic        done_real;

  always @(posedge clk) run_cyc <= mult_reset ? 0 : run_cyc + 1;
  assign done_real   = !mult_reset && (run_cyc == cur_lat);
  // Outside RUN the done line carries noise, which the controller must ignore.
  assign mult_done   = mult_reset ? done_noise : done_real;
  assign mult_result = done_real ? (override_en ? override_val : fmul(mult_dataa, mult_datab))
                                 : noise_word;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      done_noise = 1'($urandom_range(0, 1));
      noise_word = $urandom;
    end
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic int arb(input logic [NREQ-1:0] v, input int p);
    for (int i = 0; i < NREQ; i++) begin
      if (v[(p + i) % NREQ]) return (p + i) % NREQ;
    end
    return -1;
  endfunction

  // Reference model: one operation in flight, described by its timeline.
  int          m_free = 0;      // first cycle the controller is idle again
  int          m_run_lo = -1;   // first RUN cycle of current op
  int          m_resp_cyc = -1; // RESP cycle of current op
  int          m_idx = 0;
  int          m_ptr = 0;
  logic [31:0] m_a = '0;
  logic [31:0] m_b = '0;
  logic [NREQ+32:0] exp_q[$];   // {onehot, timeout, result}
  logic [NREQ-1:0]  hs_last = '0;

  // Logs of observed DUT activity, read by the directed scenarios.
  int              gl_idx[$];
  logic [NREQ-1:0] rl_onehot[$];
  logic [31:0]     rl_res[$];
  logic            rl_to[$];
  int              rl_cyc[$];

  always @(negedge clk) begin : monitor
    bit              idle;
    int              g;
    int              lat;
    logic [NREQ-1:0] exp_ready;
    logic [NREQ-1:0] exp_resp;
    logic [NREQ-1:0] hs;
    logic [31:0]     res;
    logic            to;
    logic [NREQ+32:0] e;
    if (!reset_n) begin
      chk("rst_req_ready", 32'(req_ready), 32'd0);
      chk("rst_resp_valid", 32'(resp_valid), 32'd0);
      chk("rst_resp_result", resp_result, 32'd0);
      chk("rst_resp_timeout", 32'(resp_timeout), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_mult_reset", 32'(mult_reset), 32'd1);
      chk("rst_mult_dataa", mult_dataa, 32'd0);
      chk("rst_mult_datab", mult_datab, 32'd0);
      m_free = 0; m_run_lo = -1; m_resp_cyc = -1; m_ptr = 0;
      m_a = '0; m_b = '0; hs_last = '0;
      exp_q.delete();
    end else begin
      idle = (cyc >= m_free);
      exp_ready = '0;
      g = -1;
      if (idle) begin
        g = arb(req_valid, m_ptr);
        if (g >= 0) exp_ready[g] = 1'b1;
      end
      chk("req_ready", 32'(req_ready), 32'(exp_ready));
      chk("busy", 32'(busy), 32'(!idle));
      chk("mult_reset", 32'(mult_reset), 32'(!(cyc >= m_run_lo && cyc < m_resp_cyc)));
      chk("mult_dataa", mult_dataa, m_a);
      chk("mult_datab", mult_datab, m_b);
      exp_resp = (cyc == m_resp_cyc) ? NREQ'(1 << m_idx) : '0;
      chk("resp_valid", 32'(resp_valid), 32'(exp_resp));
      if (resp_valid != '0) begin
        rl_onehot.push_back(resp_valid);
        rl_res.push_back(resp_result);
        rl_to.push_back(resp_timeout);
        rl_cyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          chk("resp_unexpected", 32'(resp_valid), 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("resp_onehot", 32'(resp_valid), 32'(e[NREQ+32:33]));
          chk("resp_timeout", 32'(resp_timeout), 32'(e[32]));
          chk("resp_result", resp_result, e[31:0]);
        end
      end
      if (req_ready != '0) chk("ready_onehot", 32'($countones(req_ready)), 32'd1);
      hs = req_valid & req_ready;
      hs_last = hs;
      for (int i = 0; i < NREQ; i++) if (hs[i]) gl_idx.push_back(i);
      if (g >= 0) begin
        lat = lat_mode ? lat_fixed : $urandom_range(0, TIMEOUT + 2);
        cur_lat = lat;
        m_idx = g;
        m_a = req_dataa[32*g +: 32];
        m_b = req_datab[32*g +: 32];
        m_run_lo = cyc + 2;
        if (lat <= TIMEOUT - 1) begin
          m_resp_cyc = cyc + 3 + lat;
          res = override_en ? override_val : fmul(m_a, m_b);
          to = 1'b0;
        end else begin
          m_resp_cyc = cyc + 2 + TIMEOUT;
          res = '0;
          to = 1'b1;
        end
        m_free = m_resp_cyc + 1;
        m_ptr = (g + 1) % NREQ;
        exp_q.push_back({NREQ'(1 << g), to, res});
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    req_valid = '0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic request(input int i, input logic [31:0] a, input logic [31:0] b, output int t);
    @(posedge clk);
    #1;
    req_valid[i] = 1'b1;
    req_dataa[32*i +: 32] = a;
    req_datab[32*i +: 32] = b;
    t = -1;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      #1;
      if (req_ready[i]) begin
        t = cyc;
        break;
      end
    end
    if (t < 0) chk("handshake_wait", 32'(req_ready[i]), 32'd1);
    @(posedge clk);
    #1;
    req_valid[i] = 1'b0;
  endtask

  task automatic wait_resps(input int target);
    for (int n = 0; n < 400; n++) begin
      if (rl_onehot.size() >= target) break;
      @(negedge clk);
      #1;
    end
    if (rl_onehot.size() < target) chk("resp_wait", 32'(rl_onehot.size()), 32'(target));
  endtask

  logic [31:0] ftab[NREQ] = '{32'h3f800000, 32'h40000000, 32'h40400000, 32'h40800000};
  logic [31:0] ptab[NREQ] = '{32'h40000000, 32'h40800000, 32'h40c00000, 32'h41000000};

  task automatic run_group(input logic [NREQ-1:0] mask, input int n, input bit hold);
    int              cnt;
    logic [NREQ-1:0] hs;
    cnt = 0;
    @(posedge clk);
    #1;
    for (int i = 0; i < NREQ; i++) begin
      if (mask[i]) begin
        req_valid[i] = 1'b1;
        req_dataa[32*i +: 32] = 32'h40000000;
        req_datab[32*i +: 32] = ftab[i];
      end
    end
    for (int it = 0; it < 400 && cnt < n; it++) begin
      @(negedge clk);
      #1;
      hs = req_valid & req_ready;
      if (hs != '0) cnt++;
      @(posedge clk);
      #1;
      if (cnt >= n) req_valid = '0;
      else if (!hold) req_valid = req_valid & ~hs;
    end
    if (cnt < n) begin
      chk("group_grants", 32'(cnt), 32'(n));
      req_valid = '0;
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int t;
    int n0;
    int g0;
    repeat (3) @(posedge clk);
    #1;
    chk("init_busy", 32'(busy), 32'd0);
    chk("init_mult_reset", 32'(mult_reset), 32'd1);
    reset_n = 1'b1;
    chk("fmul_pin", fmul(32'h3fc00000, 32'hbfc00000), 32'hc0100000);

    // Single request
    lat_mode = 1'b1; lat_fixed = 3;
    n0 = rl_onehot.size();
    request(0, 32'h3fc00000, 32'hbfc00000, t);
    wait_resps(n0 + 1);
    chk("single_onehot", 32'(rl_onehot[$]), 32'h1);
    chk("single_result", rl_res[$], 32'hc0100000);
    chk("single_timeout", 32'(rl_to[$]), 32'd0);
    chk("single_latency", 32'(rl_cyc[$] - t), 32'd6);

    // All four requesters valid and held
    do_reset();
    lat_fixed = 2;
    n0 = rl_onehot.size();
    g0 = gl_idx.size();
    run_group(4'b1111, 5, 1'b1);
    wait_resps(n0 + 5);
    for (int k = 0; k < 5; k++) begin
      if (gl_idx.size() > g0 + k && rl_res.size() > n0 + k) begin
        chk("rr_order", 32'(gl_idx[g0 + k]), 32'(k % NREQ));
        chk("rr_result", rl_res[n0 + k], ptab[k % NREQ]);
      end else begin
        chk("rr_count", 32'(gl_idx.size()), 32'(g0 + 5));
      end
    end

    // Watchdog timeout, then a normal request
    lat_fixed = 1000;
    n0 = rl_onehot.size();
    request(1, 32'h40000000, 32'h40000000, t);
    wait_resps(n0 + 1);
    chk("to_onehot", 32'(rl_onehot[$]), 32'h2);
    chk("to_result", rl_res[$], 32'd0);
    chk("to_timeout", 32'(rl_to[$]), 32'd1);
    chk("to_latency", 32'(rl_cyc[$] - t), 32'd18);
    lat_fixed = 1;
    request(2, 32'h40000000, 32'h40400000, t);
    wait_resps(n0 + 2);
    chk("after_to_result", rl_res[$], 32'h40c00000);
    chk("after_to_timeout", 32'(rl_to[$]), 32'd0);
    chk("after_to_latency", 32'(rl_cyc[$] - t), 32'd4);

    // Done on the final RUN cycle
    lat_fixed = 15;
    override_en = 1'b1;
    override_val = 32'h12345678;
    n0 = rl_onehot.size();
    request(0, 32'h40000000, 32'h40000000, t);
    wait_resps(n0 + 1);
    chk("final_timeout", 32'(rl_to[$]), 32'd0);
    chk("final_result", rl_res[$], 32'h12345678);
    chk("final_latency", 32'(rl_cyc[$] - t), 32'd18);
    override_en = 1'b0;

    // Reset during RUN
    lat_fixed = 10;
    request(3, 32'h40000000, 32'h40400000, t);
    while (cyc < t + 4) begin
      @(posedge clk);
      #1;
    end
    chk("pre_rst_mult_reset", 32'(mult_reset), 32'd0);
    reset_n = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_mult_reset", 32'(mult_reset), 32'd1);
    chk("midrst_resp_valid", 32'(resp_valid), 32'd0);
    chk("midrst_mult_dataa", mult_dataa, 32'd0);
    n0 = rl_onehot.size();
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (20) @(negedge clk);
    #1;
    chk("midrst_no_resp", 32'(rl_onehot.size()), 32'(n0));
    lat_fixed = 2;
    request(2, 32'h40000000, 32'h40000000, t);
    wait_resps(n0 + 1);
    chk("post_rst_grant", 32'(gl_idx[$]), 32'd2);
    chk("post_rst_result", rl_res[$], 32'h40800000);

    // Pointer wrap
    n0 = rl_onehot.size();
    run_group(4'b1000, 1, 1'b0);
    wait_resps(n0 + 1);
    run_group(4'b1001, 2, 1'b0);
    wait_resps(n0 + 3);
    chk("wrap_first", 32'(gl_idx[gl_idx.size() - 2]), 32'd0);
    chk("wrap_second", 32'(gl_idx[$]), 32'd3);

    // Randomized traffic
    lat_mode = 1'b0;
    repeat (600) begin
      @(posedge clk);
      #1;
      for (int i = 0; i < NREQ; i++) begin
        if (req_valid[i]) begin
          if (hs_last[i]) begin
            if ($urandom_range(0, 2) == 0) begin
              req_dataa[32*i +: 32] = rand_float();
              req_datab[32*i +: 32] = rand_float();
            end else begin
              req_valid[i] = 1'b0;
              req_dataa[32*i +: 32] = $urandom;
              req_datab[32*i +: 32] = $urandom;
            end
          end
        end else if ($urandom_range(0, 3) == 0) begin
          req_valid[i] = 1'b1;
          req_dataa[32*i +: 32] = rand_float();
          req_datab[32*i +: 32] = rand_float();
        end else begin
          req_dataa[32*i +: 32] = $urandom;
          req_datab[32*i +: 32] = $urandom;
        end
      end
    end
    @(posedge clk);
    #1;
    req_valid = '0;
    repeat (40) @(posedge clk);
    #1;
    chk("exp_q_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, %0d checks, %0d errors", checks, errors);
    $fatal(1, "global timeout");
  end

endmodule
